fetch_unit: RTL



---
 rtl/fetch_pkg.sv | 20 ++
 rtl/next_pc_calc.sv | 32 +++
 rtl/fetch_unit.sv | 97 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
// Optional cycle counter enabled by FETCH_CYCLE_CNT_EN.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [8:0] HALT_INST_DEF = 9'b111_111_111;
    localparam int         CNT_W         = 16;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] c
    );
        return (&c) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: stall, halt, branch, sequential.
// Address arithmetic wraps at 2**A.
module next_pc_calc #(
    parameter int A = 10
) (
    input  logic [A-1:0] pc,
    input  logic         branch_en,
    input  logic         branch_rel,
    input  logic [A-1:0] target,
    input  logic         stall,
    input  logic         halt,
    output logic [A-1:0] next_pc
);

    logic [A-1:0] pc_seq;
    logic [A-1:0] pc_rel;

    assign pc_seq = pc + 1'b1;
    assign pc_rel = pc + target;

    always_comb begin
        next_pc = pc_seq;
        priority case (1'b1)
            stall:                    next_pc = pc;
            halt:                     next_pc = pc;
            branch_en && !branch_rel: next_pc = target;
            branch_en:                next_pc = pc_rel;
            default:                  next_pc = pc_seq;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// PC register and IDLE/RUN/DONE fetch sequencer in front of the ROM.
// Define FETCH_CYCLE_CNT_EN to add the CycleCount output.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int           A         = 10,
    parameter int           W         = 9,
    parameter logic [W-1:0] HALT_INST = HALT_INST_DEF
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [A-1:0] StartAddr,
    input  logic [W-1:0] InstIn,
    input  logic         BranchEn,
    input  logic         BranchRel,
    input  logic [A-1:0] Target,
    input  logic         Stall,
    output logic [A-1:0] InstAddress,
    output logic         InstValid,
    output logic         Done
`ifdef FETCH_CYCLE_CNT_EN
    ,
    output logic [CNT_W-1:0] CycleCount
`endif
);

    state_t       state;
    logic [A-1:0] pc;
    logic [A-1:0] next_pc;
    logic         halt;

    assign halt        = (InstIn == HALT_INST);
    assign InstAddress = pc;
    assign InstValid   = (state == RUN);

    next_pc_calc #(
        .A(A)
    ) u_next_pc (
        .pc        (pc),
        .branch_en (BranchEn),
        .branch_rel(BranchRel),
        .target    (Target),
        .stall     (Stall),
        .halt      (halt),
        .next_pc   (next_pc)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            pc    <= '0;
            Done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        pc    <= StartAddr;
                        state <= RUN;
                    end
                end
                RUN: begin
                    pc <= next_pc;
                    // A stalled halt is not retired yet
                    if (!Stall && halt) begin
                        state <= DONE;
                        Done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (Start) begin
                        pc    <= StartAddr;
                        Done  <= 1'b0;
                        state <= RUN;
                    end
                end
                default: begin
                    state <= IDLE;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_CYCLE_CNT_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            CycleCount <= '0;
        end else if (state == RUN) begin
            CycleCount <= sat_inc(CycleCount);
        end else if (Start) begin
            CycleCount <= '0;
        end
    end
`endif

endmodule
